ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter: DATA_W, 32, datapath width.
REQ-002 SHALL have parameter: REG_ADDR_W, 5, register-index width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port: reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port: in_valid  in  1  execute-stage entry present.
REQ-007 SHALL have port: in_ready  out  1  stage can accept an entry.
REQ-008 SHALL have port: resultado  in  DATA_W  ALU result.
REQ-009 SHALL have port: isZero  in  1  ALU zero flag.
REQ-010 SHALL have port: store_data  in  DATA_W  rt value for stores.
REQ-011 SHALL have port: rd_addr  in  REG_ADDR_W  destination register.
REQ-012 SHALL have ports: reg_write, mem_read, mem_write, branch  in  1 each  control bits.
REQ-013 SHALL have port: branch_target  in  DATA_W  computed branch PC.
REQ-014 SHALL have port: flush  in  1  discard all held entries.
REQ-015 SHALL have port: out_valid  out  1  memory-stage entry present.
REQ-016 SHALL have port: out_ready  in  1  memory stage accepts.
REQ-017 SHALL have ports: out_result, out_store_data  out  DATA_W; out_rd  out  REG_ADDR_W; out_reg_write, out_mem_read, out_mem_write  out  1.
REQ-018 SHALL have ports: branch_taken  out  1; branch_pc  out  DATA_W.

Function
REQ-019 SHALL accept an entry on a rising edge when in_valid && in_ready; SHALL transfer an entry out when out_valid && out_ready.
REQ-020 SHALL hold up to 2 entries (main + skid); in_ready SHALL be registered and equal 1 iff the skid entry is empty.
REQ-021 SHALL present an accepted entry on the outputs 1 cycle after acceptance when empty; throughput 1 entry/cycle while out_ready=1.
REQ-022 On acceptance while main is held and not leaving, SHALL write the skid entry; on main leaving, skid SHALL move to main in the same edge.
REQ-023 Outputs SHALL be stable while out_valid && !out_ready.
REQ-024 SHALL force out_reg_write=0 when rd_addr==0.
REQ-025 SHALL force out_mem_write=0 when mem_read and mem_write are both 1.
REQ-026 On acceptance with branch && isZero, SHALL pulse branch_taken for exactly 1 cycle on the next cycle, with branch_pc=branch_target; otherwise branch_taken=0.
REQ-027 flush SHALL clear both entries on that edge, drop any entry offered in that cycle, set in_ready=1, and suppress branch_taken; flush has priority over all handshakes.

Reset
REQ-028 While reset_n=0: out_valid=0, branch_taken=0, all data/control outputs 0, both entries empty, in_ready=1.
REQ-029 Reset asserted mid-transfer SHALL discard all held entries immediately.

Configuration
REQ-030 With EX_MEM_FWD_EN defined: outputs fwd_valid (1), fwd_rd (REG_ADDR_W), fwd_data (DATA_W); fwd_valid = out_valid && out_reg_write && !out_mem_read, fwd_rd=out_rd, fwd_data=out_result; reset value 0.
REQ-031 Without EX_MEM_FWD_EN: forwarding ports and logic SHALL be absent.

Structure
REQ-032 Shared package mips_pkg SHALL hold DATA_W/REG_ADDR_W defaults, the zero-register constant, and the EX/MEM entry struct type.
REQ-033 The 2-entry valid/ready buffer SHALL be sub-module skid_buffer2, parameterized by entry width.

Verification
REQ-034 Single entry resultado=0x00000005, rd=3, reg_write=1, out_ready=1 -> out_valid=1 next cycle, out_result=5, out_rd=3, then out_valid=0.
REQ-035 out_ready=0, 3 back-to-back entries -> first two held, in_ready=0 after the 2nd; out_ready=1 -> outputs in order A, B, no loss/duplication.
REQ-036 branch=1, isZero=1, branch_target=0x00400020 -> branch_taken=1 for one cycle, branch_pc=0x00400020; isZero=0 -> no pulse.
REQ-037 rd_addr=0, reg_write=1 -> out_reg_write=0; mem_read=mem_write=1 -> out_mem_write=0.
REQ-038 2 entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no branch_taken; reset_n=0 mid-stall -> all outputs 0 immediately.
REQ-039 EX_MEM_FWD_EN defined, entry rd=7, reg_write=1, mem_read=0, result 0x1234 -> fwd_valid=1, fwd_rd=7, fwd_data=0x1234; mem_read=1 -> fwd_valid=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: default widths, the zero register index,
// the EX/MEM entry layout and the skid buffer occupancy states.
package mips_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int ZERO_REG       = 0;

  // Field order here matches the flat packing used inside ex_mem_stage.
  typedef struct packed {
    logic [DEF_DATA_W-1:0]     result;
    logic [DEF_DATA_W-1:0]     store_data;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
  } ex_mem_entry_t;

  // Bit 0 = main entry valid, bit 1 = skid entry valid.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b11
  } buf_state_t;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer (main + skid). in_ready and out_valid are
// flop bits of the occupancy state, so neither depends on the far side.
module skid_buffer2
  import mips_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output buf_state_t   state
);

  // Handshake: a word moves on a rising edge only when valid && ready are
  // both high; valid never waits on ready, data holds while valid && !ready.
  buf_state_t   state_nxt;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_fire;
  logic         out_fire;
  logic         load_main;
  logic         load_skid;
  logic         main_from_skid;

  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_nxt = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            load_skid = 1'b1;
            state_nxt = BUF_TWO;
          end else if (out_fire) begin
            state_nxt = BUF_EMPTY;
          end
        end
        BUF_TWO: begin
          if (out_fire) begin
            main_from_skid = 1'b1;
            state_nxt      = BUF_ONE;
          end
        end
        default: state_nxt = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= BUF_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer and a one-cycle
// branch-taken pulse. Define EX_MEM_FWD_EN to add the forwarding outputs.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     resultado,
  input  logic                  isZero,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch,
  input  logic [DATA_W-1:0]     branch_target,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_pc,
  output buf_state_t            dbg_state
`ifdef EX_MEM_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  localparam int ENTRY_W = 2 * DATA_W + REG_ADDR_W + 3;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic               accept;
  logic               take_branch;

  // Control bits are sanitised on entry so held entries are already clean.
  assign in_entry = {resultado, store_data, rd_addr,
                     reg_write && (rd_addr != REG_ADDR_W'(ZERO_REG)),
                     mem_read,
                     mem_write && !mem_read};

  assign {out_result, out_store_data, out_rd,
          out_reg_write, out_mem_read, out_mem_write} = out_entry;

  skid_buffer2 #(
    .W(ENTRY_W)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry),
    .state     (dbg_state)
  );

  assign accept      = in_valid && in_ready && !flush;
  assign take_branch = accept && branch && isZero;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      branch_taken <= 1'b0;
      branch_pc    <= '0;
    end else begin
      branch_taken <= take_branch;
      if (take_branch) begin
        branch_pc <= branch_target;
      end
    end
  end

`ifdef EX_MEM_FWD_EN
  // Loads are excluded: their result is an address, not the register value.
  assign fwd_valid = out_valid && out_reg_write && !out_mem_read;
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_result;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios plus a random
// run against a queue-based model. Forwarding checks need EX_MEM_FWD_EN.
module tb_ex_mem_stage;
  import mips_pkg::*;

  localparam int EW = $bits(ex_mem_entry_t);

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] resultado, store_data, branch_target;
  logic        is_zero;
  logic [4:0]  rd_addr;
  logic        reg_write, mem_read, mem_write, branch, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data, branch_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write, branch_taken;
  buf_state_t  dbg_state;
`ifdef EX_MEM_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  ex_mem_stage dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .resultado(resultado), .isZero(is_zero), .store_data(store_data),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .branch_target(branch_target),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .dbg_state(dbg_state)
`ifdef EX_MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver tasks
  task automatic drive_idle();
    in_valid = 0; resultado = 0; store_data = 0; rd_addr = 0; reg_write = 0;
    mem_read = 0; mem_write = 0; branch = 0; is_zero = 0; branch_target = 0;
    flush = 0;
  endtask

  task automatic drive_entry(input logic [31:0] res, input logic [31:0] sd,
                             input logic [4:0] rd, input logic rw, input logic mr,
                             input logic mw, input logic br, input logic z,
                             input logic [31:0] bt);
    in_valid = 1; resultado = res; store_data = sd; rd_addr = rd; reg_write = rw;
    mem_read = mr; mem_write = mw; branch = br; is_zero = z; branch_target = bt;
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 0; out_ready = 1;
    drive_entry(32'hdead_beef, 32'h1, 5'd9, 1, 0, 1, 1, 1, 32'h40);
    @(negedge clock); @(negedge clock);
    n_cmp++; if ({out_valid, branch_taken} !== 2'b00) begin n_fail++;
      $display("FAIL reset_valid: got v=%0b bt=%0b want 0 0", out_valid, branch_taken); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if ({out_result, out_store_data, out_rd, out_reg_write, out_mem_read,
                  out_mem_write, branch_pc} !== '0) begin n_fail++;
      $display("FAIL reset_outputs: got res=%h rd=%0d pc=%h want all 0",
               out_result, out_rd, branch_pc); end
    reset_n = 1; drive_idle();
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_release: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1;
    drive_entry(32'h5, 32'h0, 5'd3, 1, 0, 0, 0, 0, 32'h0);
    cycle(); drive_idle();
    n_cmp++; if ({out_valid, out_result, out_rd, out_reg_write} !== {1'b1, 32'h5, 5'd3, 1'b1}) begin
      n_fail++; $display("FAIL single_out: got v=%0b res=%h rd=%0d rw=%0b want 1 5 3 1",
                         out_valid, out_result, out_rd, out_reg_write); end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL single_drain: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive_entry(32'hA, 32'hA0, 5'd1, 1, 0, 0, 0, 0, 32'h0);
    cycle();
    drive_entry(32'hB, 32'hB0, 5'd2, 1, 0, 1, 0, 0, 32'h0);
    n_cmp++; if ({out_valid, in_ready, out_result} !== {1'b1, 1'b1, 32'hA}) begin n_fail++;
      $display("FAIL b2b_first: got v=%0b rdy=%0b res=%h want 1 1 A", out_valid, in_ready, out_result); end
    cycle();
    drive_entry(32'hC, 32'hC0, 5'd4, 1, 0, 0, 0, 0, 32'h0);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL b2b_full: got in_ready=%0b want 0", in_ready); end
    cycle(); drive_idle();
    n_cmp++; if ({out_valid, in_ready, out_result, out_store_data, out_rd} !==
                 {1'b1, 1'b0, 32'hA, 32'hA0, 5'd1}) begin n_fail++;
      $display("FAIL b2b_stall: got v=%0b rdy=%0b res=%h sd=%h rd=%0d want 1 0 A A0 1",
               out_valid, in_ready, out_result, out_store_data, out_rd); end
    out_ready = 1;
    cycle();
    n_cmp++; if ({out_valid, in_ready, out_result, out_rd, out_mem_write} !==
                 {1'b1, 1'b1, 32'hB, 5'd2, 1'b1}) begin n_fail++;
      $display("FAIL b2b_second: got v=%0b rdy=%0b res=%h rd=%0d mw=%0b want 1 1 B 2 1",
               out_valid, in_ready, out_result, out_rd, out_mem_write); end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_nodup: got out_valid=%0b res=%h want 0", out_valid, out_result); end
  endtask

  task automatic test_branch();
    out_ready = 1;
    drive_entry(32'h0, 32'h0, 5'd0, 0, 0, 0, 1, 1, 32'h0040_0020);
    cycle(); drive_idle();
    n_cmp++; if ({branch_taken, branch_pc} !== {1'b1, 32'h0040_0020}) begin n_fail++;
      $display("FAIL branch_pulse: got bt=%0b pc=%h want 1 00400020", branch_taken, branch_pc); end
    cycle();
    n_cmp++; if (branch_taken !== 1'b0) begin n_fail++;
      $display("FAIL branch_one_cycle: got bt=%0b want 0", branch_taken); end
    drive_entry(32'h1, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'h0040_0040);
    cycle(); drive_idle();
    n_cmp++; if (branch_taken !== 1'b0) begin n_fail++;
      $display("FAIL branch_not_zero: got bt=%0b want 0", branch_taken); end
    cycle();
  endtask

  task automatic test_sanitize();
    out_ready = 1;
    drive_entry(32'h77, 32'h0, 5'd0, 1, 0, 0, 0, 0, 32'h0);
    cycle();
    n_cmp++; if ({out_valid, out_reg_write} !== 2'b10) begin n_fail++;
      $display("FAIL sanitize_r0: got v=%0b rw=%0b want 1 0", out_valid, out_reg_write); end
    drive_entry(32'h88, 32'h9, 5'd6, 1, 1, 1, 0, 0, 32'h0);
    cycle(); drive_idle();
    n_cmp++; if ({out_valid, out_mem_read, out_mem_write, out_reg_write} !== 4'b1101) begin n_fail++;
      $display("FAIL sanitize_rw: got v=%0b mr=%0b mw=%0b rw=%0b want 1 1 0 1",
               out_valid, out_mem_read, out_mem_write, out_reg_write); end
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive_entry(32'h11, 32'h0, 5'd1, 1, 0, 0, 0, 0, 32'h0); cycle();
    drive_entry(32'h22, 32'h0, 5'd2, 1, 0, 0, 0, 0, 32'h0); cycle();
    drive_entry(32'h33, 32'h0, 5'd3, 1, 0, 0, 1, 1, 32'h100); flush = 1;
    cycle(); drive_idle();
    n_cmp++; if ({out_valid, in_ready, branch_taken} !== 3'b010) begin n_fail++;
      $display("FAIL flush_full: got v=%0b rdy=%0b bt=%0b want 0 1 0", out_valid, in_ready, branch_taken); end
    drive_entry(32'h44, 32'h0, 5'd4, 1, 0, 0, 0, 0, 32'h0); cycle();
    drive_entry(32'h55, 32'h0, 5'd5, 1, 0, 0, 1, 1, 32'h200); flush = 1;
    cycle(); drive_idle();
    n_cmp++; if ({out_valid, in_ready, branch_taken} !== 3'b010) begin n_fail++;
      $display("FAIL flush_drop: got v=%0b rdy=%0b bt=%0b want 0 1 0", out_valid, in_ready, branch_taken); end
    cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_late: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    drive_entry(32'h66, 32'h6, 5'd6, 1, 1, 0, 0, 0, 32'h0); cycle();
    drive_entry(32'h99, 32'h9, 5'd9, 1, 0, 0, 1, 1, 32'h300); cycle();
    drive_idle();
    #2 reset_n = 0;
    #1;
    n_cmp++; if ({out_valid, branch_taken, out_result, out_store_data, out_rd, out_reg_write,
                  out_mem_read, out_mem_write, branch_pc} !== '0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: got v=%0b bt=%0b res=%h rd=%0d rdy=%0b want 0 0 0 0 1",
                         out_valid, branch_taken, out_result, out_rd, in_ready); end
    @(negedge clock); reset_n = 1;
    cycle();
  endtask

`ifdef EX_MEM_FWD_EN
  task automatic test_fwd();
    out_ready = 0;
    drive_entry(32'h1234, 32'h0, 5'd7, 1, 0, 0, 0, 0, 32'h0);
    cycle(); drive_idle();
    n_cmp++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd7, 32'h1234}) begin n_fail++;
      $display("FAIL fwd_alu: got v=%0b rd=%0d data=%h want 1 7 1234", fwd_valid, fwd_rd, fwd_data); end
    out_ready = 1;
    drive_entry(32'h1234, 32'h0, 5'd7, 1, 1, 0, 0, 0, 32'h0);
    cycle(); drive_idle();
    n_cmp++; if (fwd_valid !== 1'b0) begin n_fail++;
      $display("FAIL fwd_load: got fwd_valid=%0b want 0", fwd_valid); end
    cycle();
    n_cmp++; if (fwd_valid !== 1'b0) begin n_fail++;
      $display("FAIL fwd_empty: got fwd_valid=%0b want 0", fwd_valid); end
  endtask
`endif

  // scoreboard-driven random run: the model is just an ordered queue of
  // accepted entries, capacity two, emptied by flush
  task automatic test_random();
    ex_mem_entry_t e, act, exp_e;
    logic          exp_bt;
    logic [31:0]   exp_pc;
    logic          acc;
    exp_q.delete();
    exp_bt = 0; exp_pc = 0;
    for (int i = 0; i < 600; i++) begin
      act.result = out_result; act.store_data = out_store_data; act.rd = out_rd;
      act.reg_write = out_reg_write; act.mem_read = out_mem_read; act.mem_write = out_mem_write;
      n_cmp++; if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)) begin
        n_fail++; $display("FAIL rand_hs[%0d]: got v=%0b rdy=%0b want occupancy %0d",
                           i, out_valid, in_ready, exp_q.size()); end
      if (exp_q.size() > 0) begin
        exp_e = ex_mem_entry_t'(exp_q[0]);
        n_cmp++; if (act !== exp_e) begin n_fail++;
          $display("FAIL rand_data[%0d]: got %h want %h", i, act, exp_e); end
      end
      n_cmp++; if (branch_taken !== exp_bt || (exp_bt && branch_pc !== exp_pc)) begin n_fail++;
        $display("FAIL rand_branch[%0d]: got bt=%0b pc=%h want %0b %h",
                 i, branch_taken, branch_pc, exp_bt, exp_pc); end
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      resultado     = $urandom; store_data = $urandom; branch_target = $urandom;
      rd_addr       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      reg_write     = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      branch        = 1'($urandom); is_zero = 1'($urandom);
      acc = in_valid && (exp_q.size() < 2) && !flush;
      e.result = resultado; e.store_data = store_data; e.rd = rd_addr;
      e.reg_write = reg_write && (rd_addr != 0);
      e.mem_read  = mem_read;
      e.mem_write = mem_write && !(mem_read && mem_write);
      @(posedge clock);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
      end
      exp_bt = acc && branch && is_zero;
      if (exp_bt) exp_pc = branch_target;
      @(negedge clock);
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    out_ready = 1;
    test_reset();
    test_single();
    test_back_to_back();
    test_branch();
    test_sanitize();
    test_flush();
    test_reset_mid();
`ifdef EX_MEM_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
